// File: rtl/uart_host_if.sv
// rtl/uart_host_if.sv - register-mapped host adapter between an MCU bus and a byte-level UART core
module uart_host_if #(
    parameter int DEPTH                = 4,
    parameter int DEFAULT_CLKS_PER_BIT = 868
) (
    input  logic        i_Clock,
    input  logic        rst_n,
    input  logic        i_cs,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_irq,
    output logic [31:0] o_clks_per_bit,
    output logic        o_ld_clks_per_bit,
    output logic        o_tx_dv,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_active,
    input  logic        i_tx_done,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} tx_state_t;
    tx_state_t state, state_next;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          rx_ovr, tx_ovf, ld_pending, tx_busy;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          wr_en, rd_en, tx_push, tx_drop, tx_pop;
    logic          rx_push, rx_pop, rx_drop, stat_wr, baud_wr;
    logic [31:0]   status, rd_mux;

    assign wr_en    = i_cs & i_wr;
    assign rd_en    = i_cs & i_rd;
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    assign tx_push = wr_en & (i_addr == 2'd0) & ~tx_full;
    assign tx_drop = wr_en & (i_addr == 2'd0) & tx_full;
    assign tx_pop  = (state == S_IDLE) & ~tx_empty & ~i_tx_active;
    assign stat_wr = wr_en & (i_addr == 2'd1);
    assign baud_wr = wr_en & (i_addr == 2'd2);

    // A same-cycle pop frees the slot, so a full RX FIFO only overruns without a read.
    assign rx_pop  = rd_en & (i_addr == 2'd0) & ~rx_empty;
    assign rx_push = i_rx_dv & (~rx_full | rx_pop);
    assign rx_drop = i_rx_dv & rx_full & ~rx_pop;

    assign o_irq  = ~rx_empty | rx_ovr | tx_ovf;
    assign status = {25'd0, tx_ovf, tx_busy, rx_ovr, rx_full, rx_empty, tx_empty, tx_full};

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (!tx_empty && !i_tx_active) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (i_tx_done) state_next = S_GAP;
            S_GAP:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // GAP plus the IDLE cycle keep o_tx_dv low for two cycles so the core sees a fresh rise.
    always_comb begin
        o_tx_dv = (state == S_LAUNCH) || (state == S_WAIT);
        tx_busy = (state != S_IDLE);
    end

    always_comb begin
        rd_mux = 32'd0;
        case (i_addr)
            2'd0:    rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr]};
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = o_clks_per_bit;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (tx_push) tx_mem[tx_wptr] <= i_wdata[7:0];
        if (rx_push) rx_mem[rx_wptr] <= i_rx_byte;
    end

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr           <= '0;
            tx_rptr           <= '0;
            tx_cnt            <= '0;
            rx_wptr           <= '0;
            rx_rptr           <= '0;
            rx_cnt            <= '0;
            tx_ovf            <= 1'b0;
            rx_ovr            <= 1'b0;
            o_tx_byte         <= 8'd0;
            o_rdata           <= 32'd0;
            o_rdata_valid     <= 1'b0;
            o_clks_per_bit    <= 32'(DEFAULT_CLKS_PER_BIT);
            o_ld_clks_per_bit <= 1'b0;
            ld_pending        <= 1'b1;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop) begin
                tx_rptr   <= tx_rptr + 1'b1;
                o_tx_byte <= tx_mem[tx_rptr];
            end
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);

            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);

            if (tx_drop)                     tx_ovf <= 1'b1;
            else if (stat_wr && i_wdata[6])  tx_ovf <= 1'b0;
            if (rx_drop)                     rx_ovr <= 1'b1;
            else if (stat_wr && i_wdata[4])  rx_ovr <= 1'b0;

            // The first edge after reset loads the default divisor into the core.
            ld_pending        <= 1'b0;
            o_ld_clks_per_bit <= ld_pending | baud_wr;
            if (baud_wr) o_clks_per_bit <= i_wdata;

            o_rdata_valid <= rd_en;
            if (rd_en) o_rdata <= rd_mux;
        end
    end
endmodule
